// File: rtl/mips_kernel_ctrl.sv
// Launch controller for the MIPS kernel core: loads a program into instruction
// memory under core reset, releases the core, and watches for done or timeout.
module mips_kernel_ctrl #(
    parameter int INST_LEN       = 32,
    parameter int LEN_W          = 10,
    parameter int RST_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_W          = 16
) (
    input  logic                i_sys_clk,
    input  logic                i_sys_rst,
    input  logic                i_start,
    input  logic [LEN_W-1:0]    i_prog_len,
    input  logic                i_prog_valid,
    input  logic [INST_LEN-1:0] i_prog_data,
    output logic                o_prog_ready,
    output logic [INST_LEN-1:0] o_inst_mem_data,
    output logic                o_inst_mem_wr_en,
    output logic                o_core_rst,
    input  logic                i_krnl_done,
    input  logic                i_host_mem_wr_en,
    input  logic                i_host_mem_rd_en,
    output logic                o_host_mem_wr_en,
    output logic                o_host_mem_rd_en,
    output logic                o_host_err,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_timeout,
    output logic [CNT_W-1:0]    o_cycle_count
);

    // state  | meaning
    // IDLE   | core held in reset, waiting for a start request
    // LOAD   | streaming program words into instruction memory
    // HOLD   | core reset held for RST_CYCLES after load
    // RUN    | core released, counting cycles until done or timeout
    // FINISH | one-cycle completion pulse, core back in reset
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_HOLD, S_RUN, S_FINISH} state_t;

    localparam int HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam bit                TO_EN     = (TIMEOUT_CYCLES != 0);

    state_t                state_q, state_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic [LEN_W-1:0]      load_cnt_q, load_cnt_d;
    logic [HOLD_W-1:0]     hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_inc;
    logic                  timeout_q, timeout_d;
    logic                  wr_en_q, wr_en_d;
    logic [INST_LEN-1:0]   data_q, data_d;
    logic                  ready_q, rst_q, busy_q, done_q, herr_q;
    logic                  accept;

    // ready is only ever high in LOAD, so it alone qualifies a transfer
    assign accept  = ready_q & i_prog_valid;
    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        load_cnt_d = load_cnt_q;
        hold_cnt_d = hold_cnt_q;
        cnt_d      = cnt_q;
        timeout_d  = timeout_q;
        wr_en_d    = 1'b0;
        data_d     = data_q;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    timeout_d  = 1'b0;
                    cnt_d      = '0;
                    load_cnt_d = '0;
                    hold_cnt_d = HOLD_LAST;
                    len_d      = i_prog_len;
                    state_d    = (i_prog_len != '0) ? S_LOAD : S_HOLD;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    wr_en_d    = 1'b1;
                    data_d     = i_prog_data;
                    load_cnt_d = load_cnt_q + LEN_W'(1);
                    if (load_cnt_q == len_q - LEN_W'(1)) begin
                        hold_cnt_d = HOLD_LAST;
                        state_d    = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (hold_cnt_q == '0) state_d = S_RUN;
                else                  hold_cnt_d = hold_cnt_q - HOLD_W'(1);
            end
            S_RUN: begin
                cnt_d = cnt_inc;
                if (i_krnl_done) begin
                    state_d = S_FINISH;
                end else if (TO_EN && (cnt_inc >= TO_LAST)) begin
                    timeout_d = 1'b1;
                    state_d   = S_FINISH;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Registered outputs are derived from the next state so they line up with it
    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            load_cnt_q <= '0;
            hold_cnt_q <= '0;
            cnt_q      <= '0;
            timeout_q  <= 1'b0;
            wr_en_q    <= 1'b0;
            data_q     <= '0;
            ready_q    <= 1'b0;
            rst_q      <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            herr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            load_cnt_q <= load_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            cnt_q      <= cnt_d;
            timeout_q  <= timeout_d;
            wr_en_q    <= wr_en_d;
            data_q     <= data_d;
            ready_q    <= (state_d == S_LOAD);
            rst_q      <= (state_d != S_RUN);
            busy_q     <= (state_d != S_IDLE);
            done_q     <= (state_d == S_FINISH);
            herr_q     <= (state_q == S_RUN) & (i_host_mem_wr_en | i_host_mem_rd_en);
        end
    end

    assign o_host_mem_wr_en = i_host_mem_wr_en & (state_q != S_RUN);
    assign o_host_mem_rd_en = i_host_mem_rd_en & (state_q != S_RUN);

    assign o_prog_ready     = ready_q;
    assign o_inst_mem_data  = data_q;
    assign o_inst_mem_wr_en = wr_en_q;
    assign o_core_rst       = rst_q;
    assign o_host_err       = herr_q;
    assign o_busy           = busy_q;
    assign o_done           = done_q;
    assign o_timeout        = timeout_q;
    assign o_cycle_count    = cnt_q;

endmodule

// File: tb/tb_mips_kernel_ctrl.sv
// Directed bench for mips_kernel_ctrl: a vector table for the load/hold/host-gating
// path, then hand sequences for run-to-done, timeout, gapped load and async reset.
module tb_mips_kernel_ctrl;

    localparam logic [31:0] WA = 32'h1111_0001, WB = 32'h1111_0002,
                            WC = 32'h1111_0003, WD = 32'h1111_0004,
                            WE = 32'h2222_0005, WF = 32'h2222_0006;

    logic        clk = 1'b0, rst = 1'b1;
    logic        start = 1'b0, prog_valid = 1'b0, krnl_done = 1'b0, hwr = 1'b0, hrd = 1'b0;
    logic [9:0]  prog_len = '0;
    logic [31:0] prog_data = '0;

    logic        rdy, iwr, crst, hwr_o, hrd_o, herr, busy, done, tmo;
    logic [31:0] imd;
    logic [15:0] cnt;
    logic        t_rdy, t_iwr, t_crst, t_hwr_o, t_hrd_o, t_herr, t_busy, t_done, t_tmo;
    logic [31:0] t_imd;
    logic [15:0] t_cnt;

    int n_pass = 0, n_total = 0;

    always #5 clk = ~clk;

    mips_kernel_ctrl dut (
        .i_sys_clk(clk), .i_sys_rst(rst), .i_start(start), .i_prog_len(prog_len),
        .i_prog_valid(prog_valid), .i_prog_data(prog_data), .o_prog_ready(rdy),
        .o_inst_mem_data(imd), .o_inst_mem_wr_en(iwr), .o_core_rst(crst),
        .i_krnl_done(krnl_done), .i_host_mem_wr_en(hwr), .i_host_mem_rd_en(hrd),
        .o_host_mem_wr_en(hwr_o), .o_host_mem_rd_en(hrd_o), .o_host_err(herr),
        .o_busy(busy), .o_done(done), .o_timeout(tmo), .o_cycle_count(cnt)
    );

    mips_kernel_ctrl #(.TIMEOUT_CYCLES(16)) dut_t (
        .i_sys_clk(clk), .i_sys_rst(rst), .i_start(start), .i_prog_len(prog_len),
        .i_prog_valid(prog_valid), .i_prog_data(prog_data), .o_prog_ready(t_rdy),
        .o_inst_mem_data(t_imd), .o_inst_mem_wr_en(t_iwr), .o_core_rst(t_crst),
        .i_krnl_done(krnl_done), .i_host_mem_wr_en(hwr), .i_host_mem_rd_en(hrd),
        .o_host_mem_wr_en(t_hwr_o), .o_host_mem_rd_en(t_hrd_o), .o_host_err(t_herr),
        .o_busy(t_busy), .o_done(t_done), .o_timeout(t_tmo), .o_cycle_count(t_cnt)
    );

    typedef struct {
        logic        start;
        logic [9:0]  len;
        logic        valid;
        logic [31:0] data;
        logic        hwr, hrd;
        logic        e_wr;
        logic [31:0] e_data;
        logic        e_rst, e_rdy, e_busy, e_hwr, e_hrd, e_herr;
    } vec_t;

    vec_t vec [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_total);
        $fatal(1, "watchdog");
    end

    initial begin
        //            start len   vld data hwr hrd | wr data rst rdy busy hwr hrd herr
        vec[0]  = '{1'b0, 10'd0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vec[1]  = '{1'b1, 10'd3, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vec[2]  = '{1'b0, 10'd0, 1'b1, WA,    1'b0, 1'b0, 1'b1, WA,    1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vec[3]  = '{1'b1, 10'd5, 1'b1, WB,    1'b0, 1'b0, 1'b1, WB,    1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vec[4]  = '{1'b0, 10'd0, 1'b1, WC,    1'b0, 1'b0, 1'b1, WC,    1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vec[5]  = '{1'b0, 10'd0, 1'b1, WD,    1'b0, 1'b0, 1'b0, WC,    1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vec[6]  = '{1'b0, 10'd0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, WC,    1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vec[7]  = '{1'b0, 10'd0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, WC,    1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vec[8]  = '{1'b0, 10'd0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, WC,    1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vec[9]  = '{1'b0, 10'd0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, WC,    1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vec[10] = '{1'b0, 10'd0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, WC,    1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vec[11] = '{1'b0, 10'd0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, WC,    1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        chk("rst core_rst", crst, 1);
        chk("rst busy", busy, 0);
        chk("rst ready", rdy, 0);
        chk("rst wr_en", iwr, 0);
        chk("rst data", imd, 0);
        chk("rst done", done, 0);
        chk("rst timeout", tmo, 0);
        chk("rst count", cnt, 0);
        chk("rst host_err", herr, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            start = vec[i].start; prog_len = vec[i].len; prog_valid = vec[i].valid;
            prog_data = vec[i].data; hwr = vec[i].hwr; hrd = vec[i].hrd;
            step();
            chk($sformatf("v%0d wr_en", i), iwr, vec[i].e_wr);
            chk($sformatf("v%0d data", i), imd, vec[i].e_data);
            chk($sformatf("v%0d core_rst", i), crst, vec[i].e_rst);
            chk($sformatf("v%0d ready", i), rdy, vec[i].e_rdy);
            chk($sformatf("v%0d busy", i), busy, vec[i].e_busy);
            chk($sformatf("v%0d host_wr", i), hwr_o, vec[i].e_hwr);
            chk($sformatf("v%0d host_rd", i), hrd_o, vec[i].e_hrd);
            chk($sformatf("v%0d host_err", i), herr, vec[i].e_herr);
        end
        start = 0; prog_len = '0; prog_valid = 0; prog_data = '0; hwr = 0; hrd = 0;
        chk("run count after table", cnt, 3);

        // run-to-done at run cycle 20
        repeat (16) step();
        chk("run count 19", cnt, 19);
        chk("run done low", done, 0);
        krnl_done = 1'b1;
        step();
        krnl_done = 1'b0;
        chk("done pulse", done, 1);
        chk("done count", cnt, 20);
        chk("done timeout", tmo, 0);
        chk("done core_rst", crst, 1);
        chk("done busy", busy, 1);
        step();
        chk("after done pulse", done, 0);
        chk("after done busy", busy, 0);
        chk("after done count", cnt, 20);

        // zero-length start straight into HOLD, then timeout on dut_t
        start = 1'b1; prog_len = '0;
        step();
        start = 1'b0;
        chk("len0 ready", t_rdy, 0);
        chk("len0 busy", t_busy, 1);
        chk("len0 timeout cleared", t_tmo, 0);
        chk("len0 count cleared", t_cnt, 0);
        repeat (3) step();
        chk("len0 hold core_rst", t_crst, 1);
        step();
        chk("len0 run core_rst", t_crst, 0);
        repeat (14) step();
        chk("to count 14", t_cnt, 14);
        chk("to not yet", t_tmo, 0);
        step();
        chk("to timeout", t_tmo, 1);
        chk("to done", t_done, 1);
        chk("to count", t_cnt, 15);
        chk("to core_rst", t_crst, 1);
        step();
        chk("to busy after", t_busy, 0);
        chk("to sticky", t_tmo, 1);
        krnl_done = 1'b1;
        step();
        krnl_done = 1'b0;
        chk("main done", done, 1);
        chk("main no timeout", tmo, 0);
        chk("to ignores done in idle", t_busy, 0);
        step();

        // gapped load of 2 words, start during LOAD ignored
        start = 1'b1; prog_len = 10'd2;
        step();
        start = 1'b0;
        chk("restart timeout cleared", t_tmo, 0);
        chk("restart count cleared", t_cnt, 0);
        prog_valid = 1'b1; prog_data = WE;
        step();
        chk("gap wr1", iwr, 1);
        chk("gap data1", imd, WE);
        prog_valid = 1'b0; start = 1'b1; prog_len = 10'd5;
        step();
        start = 1'b0;
        chk("gap wr idle", iwr, 0);
        chk("gap ready", rdy, 1);
        prog_valid = 1'b1; prog_data = WF;
        step();
        prog_valid = 1'b0;
        chk("gap wr2", iwr, 1);
        chk("gap data2", imd, WF);
        chk("gap ready drop", rdy, 0);
        step();
        chk("gap no third write", iwr, 0);

        // async reset mid-load
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b1; prog_len = 10'd3;
        step();
        start = 1'b0;
        prog_valid = 1'b1; prog_data = WA;
        step();
        prog_valid = 1'b0;
        chk("ar first word", iwr, 1);
        #2 rst = 1'b1;
        #1;
        chk("ar wr_en", iwr, 0);
        chk("ar core_rst", crst, 1);
        chk("ar busy", busy, 0);
        chk("ar ready", rdy, 0);
        @(negedge clk);
        rst = 1'b0;
        start = 1'b1; prog_len = 10'd3;
        step();
        start = 1'b0;
        prog_valid = 1'b1; prog_data = WA;
        step();
        chk("reload data0", imd, WA);
        chk("reload ready0", rdy, 1);
        prog_data = WB;
        step();
        chk("reload ready1", rdy, 1);
        prog_data = WC;
        step();
        prog_valid = 1'b0;
        chk("reload data2", imd, WC);
        chk("reload ready drop", rdy, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
